debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 103 ++++++++++
 tb/tb_debounce_bank.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel push-button debouncer with press/release/long-press event pulses.
// Each channel has its own synchroniser, debounce counter and hold counter.
module debounce_bank #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DEB_CYCLES  = 2500000,
    parameter int unsigned LONG_CYCLES = 150000000,
    parameter int unsigned ACTIVE_LOW  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] lvl_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] rel_o,
    output logic [N_CH-1:0] long_o,
    output logic [N_CH-1:0] held_o
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic        AL_BIT = 1'(ACTIVE_LOW);

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        logic              r_meta;
        logic              r_sync;
        logic [DEB_W-1:0]  r_deb;
        logic              r_lvl;
        logic              r_press;
        logic              r_rel;
        logic [HOLD_W-1:0] r_hold;
        logic              r_long;
        logic              r_held;

        logic              w_s;
        logic [DEB_W-1:0]  w_deb_nxt;
        logic              w_lvl_nxt;
        logic [HOLD_W-1:0] w_hold_nxt;
        logic              w_long_nxt;
        logic              w_held_nxt;

        // Debounce: count consecutive disagreeing samples, any agreement restarts.
        always_comb begin
            w_s        = r_sync ^ AL_BIT;
            w_deb_nxt  = '0;
            w_lvl_nxt  = r_lvl;
            if (w_s != r_lvl) begin
                if (r_deb == DEB_W'(DEB_CYCLES - 1)) begin
                    w_lvl_nxt = w_s;
                end else begin
                    w_deb_nxt = r_deb + DEB_W'(1);
                end
            end
        end

        // Hold timer starts on the cycle after acceptance and saturates at LONG_CYCLES.
        always_comb begin
            w_hold_nxt = r_hold;
            w_long_nxt = 1'b0;
            w_held_nxt = r_held;
            if (!w_lvl_nxt) begin
                w_hold_nxt = '0;
                w_held_nxt = 1'b0;
            end else if (r_lvl && (r_hold != HOLD_W'(LONG_CYCLES))) begin
                w_hold_nxt = r_hold + HOLD_W'(1);
                if (w_hold_nxt == HOLD_W'(LONG_CYCLES)) begin
                    w_long_nxt = 1'b1;
                    w_held_nxt = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_meta  <= AL_BIT;
                r_sync  <= AL_BIT;
                r_deb   <= '0;
                r_lvl   <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_hold  <= '0;
                r_long  <= 1'b0;
                r_held  <= 1'b0;
            end else begin
                r_meta  <= btn_i[g];
                r_sync  <= r_meta;
                r_deb   <= w_deb_nxt;
                r_lvl   <= w_lvl_nxt;
                r_press <= w_lvl_nxt & ~r_lvl;
                r_rel   <= ~w_lvl_nxt & r_lvl;
                r_hold  <= w_hold_nxt;
                r_long  <= w_long_nxt;
                r_held  <= w_held_nxt;
            end
        end

        assign lvl_o[g]   = r_lvl;
        assign press_o[g] = r_press;
        assign rel_o[g]   = r_rel;
        assign long_o[g]  = r_long;
        assign held_o[g]  = r_held;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised and directed stimulus for debounce_bank, checked cycle by cycle
// against a window-based reference model through an expectation queue.
module tb_debounce_bank;

    localparam int N    = 2;
    localparam int DEB  = 4;
    localparam int LONG = 10;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] btn_i;
    logic [N-1:0] lvl_o, press_o, rel_o, long_o, held_o;

    debounce_bank #(
        .N_CH(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_i),
        .lvl_o(lvl_o), .press_o(press_o), .rel_o(rel_o),
        .long_o(long_o), .held_o(held_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected {lvl, press, rel, long, held} after each rising edge.
    logic [5*N-1:0] exp_q[$];

    // Reference model state.
    logic [N-1:0] hist[$];      // raw inputs of the two previous edges
    logic [N-1:0] win[$];       // last DEB conditioned samples
    logic [N-1:0] m_lvl;
    int           ptime[N];     // edges since acceptance of the current press

    function automatic void model_reset();
        hist = {};
        hist.push_back('0);
        hist.push_back('0);
        win = {};
        m_lvl = '0;
        for (int c = 0; c < N; c++) ptime[c] = 0;
    endfunction

    // Predict outputs after the edge that samples raw input b.
    function automatic logic [5*N-1:0] model_edge(input logic [N-1:0] b);
        logic [N-1:0] s, nl, pr, rl, lg, hd;
        logic         all_diff;
        s = hist[0];
        void'(hist.pop_front());
        hist.push_back(b);
        win.push_back(s);
        if (win.size() > DEB) void'(win.pop_front());
        nl = m_lvl;
        for (int c = 0; c < N; c++) begin
            all_diff = (win.size() == DEB);
            foreach (win[i]) if (win[i][c] == m_lvl[c]) all_diff = 1'b0;
            if (all_diff) nl[c] = ~m_lvl[c];
        end
        pr = nl & ~m_lvl;
        rl = ~nl & m_lvl;
        for (int c = 0; c < N; c++) begin
            if (pr[c])      ptime[c] = 0;
            else if (nl[c]) ptime[c] = ptime[c] + 1;
            else            ptime[c] = 0;
            lg[c] = nl[c] && (ptime[c] == LONG);
            hd[c] = nl[c] && (ptime[c] >= LONG);
        end
        m_lvl = nl;
        return {nl, pr, rl, lg, hd};
    endfunction

    // Monitor: outputs are presented every cycle; pop and compare.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [5*N-1:0] e, a;
            e = exp_q.pop_front();
            a = {lvl_o, press_o, rel_o, long_o, held_o};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d lvl/press/rel/long/held got=%b want=%b",
                         cyc, a, e);
            end
        end
    end

    task automatic step(input logic [N-1:0] b);
        @(negedge clk);
        exp_q.push_back(model_edge(b));
        btn_i = b;
        cyc++;
    endtask

    task automatic hold(input logic [N-1:0] b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    // Reset pulse strictly between edges; outputs must clear without a clock.
    task automatic reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({lvl_o, press_o, rel_o, long_o, held_o} !== '0) begin
            errors++;
            $display("FAIL async_reset got=%b want=0",
                     {lvl_o, press_o, rel_o, long_o, held_o});
        end
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int run;
        logic [N-1:0] v;
        btn_i = '0;
        rst_n = 1'b0;
        model_reset();
        #12 rst_n = 1'b1;

        hold(2'b00, 5);                       // idle after reset: no pulses
        hold(2'b01, 12); hold(2'b00, 10);     // clean press/release on ch0
        for (int r = 0; r < 2; r++) begin     // sub-threshold bounce
            hold(2'b01, 3); hold(2'b00, 3);
        end
        hold(2'b00, 8);
        hold(2'b10, 30); hold(2'b00, 12);     // long press on ch1
        hold(2'b11, 5);  hold(2'b00, 12);     // simultaneous short press
        hold(2'b01, 12);                      // reset during a hold
        reset_pulse();
        hold(2'b01, 25); hold(2'b00, 10);

        for (int i = 0; i < 300; i++) begin   // random bouncy traffic
            v   = N'($urandom);
            run = int'($urandom_range(1, 14));
            hold(v, run);
            if ($urandom_range(0, 40) == 0) reset_pulse();
        end
        hold(2'b00, 12);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
